// File: rtl/register_file_if.sv
// Register-file access bundle: one byte-enabled write port, busy-set port, two read ports.
// The master drives addresses and write data; the slave returns read data and busy bits.
interface register_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [WIDTH/8-1:0]   wr_be;
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [WIDTH-1:0]     rd_data_a;
    logic [ADDR_W-1:0]    rd_addr_b;
    logic [WIDTH-1:0]     rd_data_b;
    logic                 busy_set;
    logic [ADDR_W-1:0]    busy_addr;
    logic                 busy_a;
    logic                 busy_b;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be,
        output rd_addr_a, rd_addr_b, busy_set, busy_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be,
        input  rd_addr_a, rd_addr_b, busy_set, busy_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b
    );
endinterface

// File: rtl/register_file.sv
// CPU register file: 2 async read ports, 1 sync byte-enabled write port, per-register busy bits.
// Reads are combinational (optional same-cycle write forwarding); writes land at the clock edge.
// No backpressure: every request is accepted in the cycle it is presented.
module register_file #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);
    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    // Requests aimed at the hardwired zero register are dropped here once, for all consumers.
    logic wr_ok;
    logic set_ok;
    assign wr_ok  = bus.wr_en    && !(ZERO_REG != 0 && bus.wr_addr   == '0);
    assign set_ok = bus.busy_set && !(ZERO_REG != 0 && bus.busy_addr == '0);

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                               input logic [WIDTH-1:0] new_v,
                                               input logic [NB-1:0]    be);
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[bus.wr_addr] <= merge(regs[bus.wr_addr], bus.wr_data, bus.wr_be);
                busy[bus.wr_addr] <= 1'b0;
            end
            // Applied after the clear so a newly issued producer wins over the retiring one.
            if (set_ok) busy[bus.busy_addr] <= 1'b1;
        end
    end

    always_comb begin
        bus.rd_data_a = regs[bus.rd_addr_a];
        bus.busy_a    = busy[bus.rd_addr_a];
        if (BYPASS != 0 && !reset && wr_ok && bus.wr_addr == bus.rd_addr_a) begin
            bus.rd_data_a = merge(regs[bus.rd_addr_a], bus.wr_data, bus.wr_be);
            bus.busy_a    = set_ok && (bus.busy_addr == bus.wr_addr);
        end
        if (ZERO_REG != 0 && bus.rd_addr_a == '0) begin
            bus.rd_data_a = '0;
            bus.busy_a    = 1'b0;
        end
    end

    always_comb begin
        bus.rd_data_b = regs[bus.rd_addr_b];
        bus.busy_b    = busy[bus.rd_addr_b];
        if (BYPASS != 0 && !reset && wr_ok && bus.wr_addr == bus.rd_addr_b) begin
            bus.rd_data_b = merge(regs[bus.rd_addr_b], bus.wr_data, bus.wr_be);
            bus.busy_b    = set_ok && (bus.busy_addr == bus.wr_addr);
        end
        if (ZERO_REG != 0 && bus.rd_addr_b == '0) begin
            bus.rd_data_b = '0;
            bus.busy_b    = 1'b0;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues hand-computed read results,
// a negedge monitor pops and compares them against both read ports.
module tb_register_file;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    register_file_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    register_file #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
        string       name;
    } exp_t;

    exp_t q[$];
    logic chk_vld = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    always @(negedge clk) begin
        if (chk_vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: output presented with no expected entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                checks += 4;
                if (bus.rd_data_a !== e.a) begin
                    errors++;
                    $display("FAIL %s rd_data_a got %h expected %h", e.name, bus.rd_data_a, e.a);
                end
                if (bus.rd_data_b !== e.b) begin
                    errors++;
                    $display("FAIL %s rd_data_b got %h expected %h", e.name, bus.rd_data_b, e.b);
                end
                if (bus.busy_a !== e.ba) begin
                    errors++;
                    $display("FAIL %s busy_a got %b expected %b", e.name, bus.busy_a, e.ba);
                end
                if (bus.busy_b !== e.bb) begin
                    errors++;
                    $display("FAIL %s busy_b got %b expected %b", e.name, bus.busy_b, e.bb);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic bs, input logic [4:0] bsa,
                        input logic [4:0] ra, input logic [4:0] rb, input logic chk,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic eba, input logic ebb, input string nm);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.wr_be     = be;
        bus.busy_set  = bs;
        bus.busy_addr = bsa;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        chk_vld       = chk;
        if (chk) q.push_back('{a: ea, b: eb, ba: eba, bb: ebb, name: nm});
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic eba, input logic ebb, input string nm);
        step(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, ra, rb, 1'b1, ea, eb, eba, ebb, nm);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
        bus.busy_set = 1'b0; bus.busy_addr = '0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
        step(1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, "in_reset");
        for (int i = 0; i < 32; i++)
            idle(5'(i), 5'(31 - i), 32'h0, 32'h0, 1'b0, 1'b0, "reset_read");

        // Full-word write: forwarded the same cycle, stored afterwards
        step(0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, "wr_full_bypass");
        idle(5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, "wr_full_stored");

        // Partial write, bytes 0 and 2
        step(0, 1, 5, 32'h11223344, 4'b0101, 0, 0, 5, 5, 1, 32'hDE22BE44, 32'hDE22BE44, 0, 0, "wr_be_bypass");
        idle(5, 5, 32'hDE22BE44, 32'hDE22BE44, 0, 0, "wr_be_stored");

        // Zero register ignores writes and busy_set
        step(0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 5, 1, 32'h0, 32'hDE22BE44, 0, 0, "r0_wr_bypass");
        idle(0, 5, 32'h0, 32'hDE22BE44, 0, 0, "r0_wr_stored");
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, "r0_busy_set");
        idle(0, 0, 32'h0, 32'h0, 0, 0, "r0_busy_after");

        // Busy set then cleared by the write
        step(0, 0, 0, 0, 0, 1, 7, 7, 5, 1, 32'h0, 32'hDE22BE44, 0, 0, "r7_set_cycle");
        idle(7, 5, 32'h0, 32'hDE22BE44, 1, 0, "r7_busy");
        step(0, 1, 7, 32'h00000077, 4'hF, 0, 0, 7, 7, 1, 32'h77, 32'h77, 0, 0, "r7_wr_bypass");
        idle(7, 7, 32'h77, 32'h77, 0, 0, "r7_wr_stored");

        // Same-address set and clear: set wins
        step(0, 1, 9, 32'hA5A5A5A5, 4'hF, 1, 9, 9, 7, 1, 32'hA5A5A5A5, 32'h77, 1, 0, "r9_setclr_bypass");
        idle(9, 9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 1, "r9_setclr_stored");

        // Different addresses: clear r9, set r10
        step(0, 1, 9, 32'h00000001, 4'b0001, 1, 10, 9, 10, 1, 32'hA5A5A501, 32'h0, 0, 0, "diff_addr_bypass");
        idle(9, 10, 32'hA5A5A501, 32'h0, 0, 1, "diff_addr_stored");

        // wr_be=0 keeps data but still clears busy
        step(0, 0, 0, 0, 0, 1, 12, 12, 12, 1, 32'h0, 32'h0, 0, 0, "r12_set_cycle");
        idle(12, 12, 32'h0, 32'h0, 1, 1, "r12_busy");
        step(0, 1, 12, 32'hFFFFFFFF, 4'h0, 0, 0, 12, 12, 1, 32'h0, 32'h0, 0, 0, "be0_bypass");
        idle(12, 12, 32'h0, 32'h0, 0, 0, "be0_stored");

        // Reset mid-sequence dominates write and busy_set; bypass suppressed while high
        step(1, 1, 5, 32'h12345678, 4'hF, 1, 3, 5, 10, 1, 32'hDE22BE44, 32'h0, 0, 1, "reset_no_bypass");
        idle(5, 10, 32'h0, 32'h0, 0, 0, "post_reset_r5_r10");
        idle(3, 9, 32'h0, 32'h0, 0, 0, "post_reset_r3_r9");
        for (int i = 0; i < 32; i++)
            idle(5'(i), 5'(i ^ 5'h15), 32'h0, 32'h0, 1'b0, 1'b0, "post_reset_all");

        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
